alu_arb_n: RTL and testbench
============================

ALU_ARB_N -- requirements
Module: alu_arb_n

Interface
REQ-001 The block SHALL have parameter n, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have port clk_i  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports req0_valid_i / req1_valid_i  input  1  requester k has an operation pending.
REQ-005 The block SHALL have ports req0_ready_o / req1_ready_o  output  1  requester k's operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_op_i / req1_op_i  input  4  ALU opcode.
REQ-007 The block SHALL have ports req0_a_i, req0_b_i, req1_a_i, req1_b_i  input  n  operand0/operand1 per requester.
REQ-008 The block SHALL have port rsp_valid_o  output  1  result register holds a result.
REQ-009 The block SHALL have port rsp_ready_i  input  1  consumer takes the result this cycle.
REQ-010 The block SHALL have port rsp_id_o  output  1  index of the requester owning the result.
REQ-011 The block SHALL have port rsp_data_o  output  n  ALU result.
REQ-012 The block SHALL have port rsp_nz_o  output  1  result non-zero (branch flag).
REQ-013 The block SHALL have port rsp_err_o  output  1  opcode was undefined.

Function
REQ-014 Opcodes SHALL be: 0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 or, 7 and, 8 sub, 0xD sra; all others undefined.
REQ-015 Shift amount SHALL be operand1[4:0]; add/sub SHALL wrap modulo 2^n; slt signed, sltu unsigned, both returning 0 or 1.
REQ-016 Undefined opcode SHALL produce rsp_data_o=0, rsp_nz_o=0, rsp_err_o=1; defined opcodes SHALL produce rsp_err_o=0.
REQ-017 Result register "free" SHALL mean rsp_valid_o=0, or rsp_valid_o=1 and rsp_ready_i=1 in the same cycle.
REQ-018 At most one request SHALL be accepted per cycle, only when the result register is free.
REQ-019 Only one valid: that requester SHALL be granted; both valid: the requester not granted most recently SHALL be granted (round-robin).
REQ-020 The last-grant pointer SHALL update only on an accepted request.
REQ-021 reqk_ready_o SHALL be combinational: free AND reqk_valid_i AND grant to k; never both high.
REQ-022 Request accepted at edge t SHALL appear on rsp_* from after edge t (latency 1); back-to-back acceptance SHALL sustain 1 op/cycle with rsp_ready_i held high.
REQ-023 rsp_data_o, rsp_id_o, rsp_nz_o, rsp_err_o SHALL be stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-024 Drain without new accept SHALL clear rsp_valid_o next cycle; drain with accept SHALL keep rsp_valid_o=1 with new contents.
REQ-025 Requesters SHALL hold valid/op/operands stable until ready; block SHALL not depend on this for correctness of other requester.
REQ-026 States: EMPTY (rsp_valid_o=0) and FULL (rsp_valid_o=1); EMPTY->FULL on accept; FULL->EMPTY on drain without accept; otherwise hold.

Reset
REQ-027 On rst_i=1 at a clock edge: rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_nz_o=0, rsp_err_o=0, state EMPTY, last-grant pointer=1 (requester 0 wins first tie).
REQ-028 reqk_ready_o SHALL be 0 in any cycle with rst_i=1; a result pending at reset SHALL be discarded.

Structure
REQ-029 Opcode constants and the EMPTY/FULL state enum SHALL live in shared package alu_pkg.
REQ-030 The ALU datapath SHALL be one combinational sub-module alu_core_n (n-bit, opcode in, result/nz/err out), fed by a grant mux.

Verification
REQ-031 Reset then req0 add 5+7, rsp_ready_i=1 -> next cycle rsp_valid_o=1, id 0, data 12, nz 1, err 0.
REQ-032 Both valid every cycle, rsp_ready_i=1 -> grants alternate 0,1,0,1 starting with 0; one result per cycle.
REQ-033 req1 sub 3-3 with rsp_ready_i=0 for 4 cycles -> data 0, nz 0 held stable; req ready low until drain.
REQ-034 slt 0xFFFFFFFF,1 -> 1; sltu same -> 0; sra 0x80000000 by 4 -> 0xF8000000; srl same -> 0x08000000.
REQ-035 Opcode 0xF -> data 0, nz 0, err 1.
REQ-036 rst_i asserted while FULL with rsp_ready_i=0 -> next cycle rsp_valid_o=0; next tie grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and result-register state encoding shared by the ALU arbiter
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SLL  = 4'h1;
    localparam logic [3:0] OP_SLT  = 4'h2;
    localparam logic [3:0] OP_SLTU = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'hD;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/alu_arb_n_if.sv
// alu_arb_n_if: two requester channels and one result channel of the arbitrated ALU
interface alu_arb_n_if #(parameter int n = 32);
    logic         req0_valid_i, req1_valid_i;
    logic         req0_ready_o, req1_ready_o;
    logic [3:0]   req0_op_i, req1_op_i;
    logic [n-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic         rsp_valid_o, rsp_ready_i, rsp_id_o;
    logic [n-1:0] rsp_data_o;
    logic         rsp_nz_o, rsp_err_o;
    modport master (
        output req0_valid_i, req1_valid_i, req0_op_i, req1_op_i,
               req0_a_i, req0_b_i, req1_a_i, req1_b_i, rsp_ready_i,
        input  req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o,
               rsp_data_o, rsp_nz_o, rsp_err_o
    );
    modport slave (
        input  req0_valid_i, req1_valid_i, req0_op_i, req1_op_i,
               req0_a_i, req0_b_i, req1_a_i, req1_b_i, rsp_ready_i,
        output req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o,
               rsp_data_o, rsp_nz_o, rsp_err_o
    );
endinterface

// File: rtl/alu_core_n.sv
// alu_core_n: combinational n-bit ALU with non-zero and undefined-opcode flags
module alu_core_n
    import alu_pkg::*;
#(parameter int n = 32) (
    input  logic [3:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] y,
    output logic         nz,
    output logic         err
);
    logic [4:0] sh;
    assign sh = b[4:0];
    // opcode decode; undefined opcodes yield zero with err set
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SLL:  y = a << sh;
            OP_SLT:  y = {{(n-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: y = {{(n-1){1'b0}}, a < b};
            OP_XOR:  y = a ^ b;
            OP_SRL:  y = a >> sh;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_SUB:  y = a - b;
            OP_SRA:  y = $unsigned($signed(a) >>> sh);
            default: err = 1'b1;
        endcase
    end
    assign nz = |y;
endmodule

// File: rtl/alu_arb_n.sv
// alu_arb_n: round-robin arbitration of two requesters onto one ALU with a single result register
module alu_arb_n
    import alu_pkg::*;
#(parameter int n = 32) (
    input  logic clk_i,
    input  logic rst_i,
    alu_arb_n_if.slave bus
);
    state_t       state;
    logic         last, gnt, free, accept;
    logic [3:0]   op_m;
    logic [n-1:0] a_m, b_m, y;
    logic         nz, err;

    // both valid goes to whoever was not granted last; otherwise the lone valid requester
    assign gnt    = (bus.req0_valid_i && bus.req1_valid_i) ? ~last : bus.req1_valid_i;
    assign free   = (state == EMPTY) || bus.rsp_ready_i;
    assign bus.req0_ready_o = !rst_i && free && bus.req0_valid_i && !gnt;
    assign bus.req1_ready_o = !rst_i && free && bus.req1_valid_i && gnt;
    assign accept = bus.req0_ready_o || bus.req1_ready_o;

    assign op_m = gnt ? bus.req1_op_i : bus.req0_op_i;
    assign a_m  = gnt ? bus.req1_a_i  : bus.req0_a_i;
    assign b_m  = gnt ? bus.req1_b_i  : bus.req0_b_i;

    alu_core_n #(.n(n)) u_core (
        .op  (op_m),
        .a   (a_m),
        .b   (b_m),
        .y   (y),
        .nz  (nz),
        .err (err)
    );

    // result register and grant pointer; contents only change on an accepted request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= EMPTY;
            last           <= 1'b1;
            bus.rsp_id_o   <= 1'b0;
            bus.rsp_data_o <= '0;
            bus.rsp_nz_o   <= 1'b0;
            bus.rsp_err_o  <= 1'b0;
        end else begin
            state <= accept ? FULL : (bus.rsp_ready_i ? EMPTY : state);
            if (accept) begin
                last           <= gnt;
                bus.rsp_id_o   <= gnt;
                bus.rsp_data_o <= y;
                bus.rsp_nz_o   <= nz;
                bus.rsp_err_o  <= err;
            end
        end
    end

    assign bus.rsp_valid_o = (state == FULL);
endmodule

// File: tb/tb_alu_arb_n.sv
// tb_alu_arb_n: directed vector table plus handshake sequences for alu_arb_n
module tb_alu_arb_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_arb_n_if #(.n(32)) bus ();
    alu_arb_n #(.n(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, y;
        logic        nz, err;
    } vec_t;
    vec_t v[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = '{4'h0, 32'd5,        32'd7,        32'd12,       1'b1, 1'b0};
        v[1]  = '{4'h8, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b1, 1'b0};
        v[2]  = '{4'h1, 32'd1,        32'h0000003F, 32'h80000000, 1'b1, 1'b0};
        v[3]  = '{4'h2, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1'b0};
        v[4]  = '{4'h3, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0};
        v[5]  = '{4'hD, 32'h80000000, 32'd4,        32'hF8000000, 1'b1, 1'b0};
        v[6]  = '{4'h5, 32'h80000000, 32'd4,        32'h08000000, 1'b1, 1'b0};
        v[7]  = '{4'h4, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b1, 1'b0};
        v[8]  = '{4'h6, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b1, 1'b0};
        v[9]  = '{4'h7, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b1, 1'b0};
        v[10] = '{4'h0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0};
        v[11] = '{4'hF, 32'd9,        32'd9,        32'd0,        1'b0, 1'b1};
        v[12] = '{4'h9, 32'd9,        32'd3,        32'd0,        1'b0, 1'b1};

        bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1;
        bus.req0_op_i = 4'h0; bus.req1_op_i = 4'h0;
        bus.req0_a_i = 32'd1; bus.req0_b_i = 32'd1;
        bus.req1_a_i = 32'd2; bus.req1_b_i = 32'd2;
        bus.rsp_ready_i = 1'b1;
        #1;
        chk("rst_ready0", {31'b0, bus.req0_ready_o}, 32'd0);
        chk("rst_ready1", {31'b0, bus.req1_ready_o}, 32'd0);
        step;
        step;
        rst = 1'b0;
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
        #1;
        chk("rst_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
        chk("rst_id",    {31'b0, bus.rsp_id_o},    32'd0);
        chk("rst_data",  bus.rsp_data_o,            32'd0);
        chk("rst_nz",    {31'b0, bus.rsp_nz_o},    32'd0);
        chk("rst_err",   {31'b0, bus.rsp_err_o},   32'd0);

        for (int i = 0; i < 13; i++) begin
            bus.req0_valid_i = 1'b1;
            bus.req0_op_i = v[i].op; bus.req0_a_i = v[i].a; bus.req0_b_i = v[i].b;
            bus.rsp_ready_i = 1'b1;
            #1;
            chk($sformatf("v%0d_ready0", i), {31'b0, bus.req0_ready_o}, 32'd1);
            chk($sformatf("v%0d_ready1", i), {31'b0, bus.req1_ready_o}, 32'd0);
            step;
            bus.req0_valid_i = 1'b0;
            #1;
            chk($sformatf("v%0d_valid", i), {31'b0, bus.rsp_valid_o}, 32'd1);
            chk($sformatf("v%0d_id", i),    {31'b0, bus.rsp_id_o},    32'd0);
            chk($sformatf("v%0d_data", i),  bus.rsp_data_o,            v[i].y);
            chk($sformatf("v%0d_nz", i),    {31'b0, bus.rsp_nz_o},    {31'b0, v[i].nz});
            chk($sformatf("v%0d_err", i),   {31'b0, bus.rsp_err_o},   {31'b0, v[i].err});
        end
        step;
        chk("drain_valid", {31'b0, bus.rsp_valid_o}, 32'd0);

        bus.req1_valid_i = 1'b1; bus.req1_op_i = 4'h8;
        bus.req1_a_i = 32'd3; bus.req1_b_i = 32'd3;
        bus.rsp_ready_i = 1'b0;
        #1;
        chk("hold_accept_ready1", {31'b0, bus.req1_ready_o}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            step;
            bus.req1_op_i = 4'h0; bus.req1_a_i = 32'd1; bus.req1_b_i = 32'd1;
            #1;
            chk($sformatf("hold%0d_valid", k),  {31'b0, bus.rsp_valid_o},  32'd1);
            chk($sformatf("hold%0d_id", k),     {31'b0, bus.rsp_id_o},     32'd1);
            chk($sformatf("hold%0d_data", k),   bus.rsp_data_o,             32'd0);
            chk($sformatf("hold%0d_nz", k),     {31'b0, bus.rsp_nz_o},     32'd0);
            chk($sformatf("hold%0d_ready1", k), {31'b0, bus.req1_ready_o}, 32'd0);
        end
        bus.rsp_ready_i = 1'b1;
        #1;
        chk("drain_accept_ready1", {31'b0, bus.req1_ready_o}, 32'd1);
        step;
        bus.req1_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
        #1;
        chk("drain_accept_valid", {31'b0, bus.rsp_valid_o}, 32'd1);
        chk("drain_accept_data",  bus.rsp_data_o,            32'd2);
        chk("drain_accept_id",    {31'b0, bus.rsp_id_o},    32'd1);

        bus.rsp_ready_i = 1'b1;
        bus.req0_valid_i = 1'b1; bus.req0_op_i = 4'h0;
        bus.req0_a_i = 32'd9; bus.req0_b_i = 32'd0;
        #1;
        chk("pre_rst_ready0", {31'b0, bus.req0_ready_o}, 32'd1);
        step;
        bus.req0_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
        #1;
        chk("pre_rst_valid", {31'b0, bus.rsp_valid_o}, 32'd1);
        chk("pre_rst_data",  bus.rsp_data_o,            32'd9);
        rst = 1'b1;
        bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1;
        #1;
        chk("mid_rst_ready0", {31'b0, bus.req0_ready_o}, 32'd0);
        chk("mid_rst_ready1", {31'b0, bus.req1_ready_o}, 32'd0);
        step;
        rst = 1'b0;
        #1;
        chk("post_rst_valid",  {31'b0, bus.rsp_valid_o},  32'd0);
        chk("post_rst_data",   bus.rsp_data_o,             32'd0);
        chk("post_rst_id",     {31'b0, bus.rsp_id_o},     32'd0);
        chk("post_rst_ready0", {31'b0, bus.req0_ready_o}, 32'd1);
        chk("post_rst_ready1", {31'b0, bus.req1_ready_o}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            logic        g;
            logic [31:0] e;
            g = i[0];
            bus.req0_op_i = 4'h0; bus.req0_a_i = i; bus.req0_b_i = 32'd100;
            bus.req1_op_i = 4'h6; bus.req1_a_i = i << 8; bus.req1_b_i = 32'd1;
            bus.rsp_ready_i = 1'b1;
            e = g ? ((i << 8) | 1) : (i + 100);
            #1;
            chk($sformatf("rr%0d_ready0", i), {31'b0, bus.req0_ready_o}, {31'b0, !g});
            chk($sformatf("rr%0d_ready1", i), {31'b0, bus.req1_ready_o}, {31'b0, g});
            step;
            #1;
            chk($sformatf("rr%0d_valid", i), {31'b0, bus.rsp_valid_o}, 32'd1);
            chk($sformatf("rr%0d_id", i),    {31'b0, bus.rsp_id_o},    {31'b0, g});
            chk($sformatf("rr%0d_data", i),  bus.rsp_data_o,            e);
        end
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
        step;
        chk("final_drain_valid", {31'b0, bus.rsp_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
